// File: rtl/page_cmd_exec.sv
// Page-command executor: expands one page command into NAND CMD/ADDR ops,
// times the confirm delay, polls R/B# and reports per-request completion.
module page_cmd_exec #(
  parameter logic [23:0] RB_TIMEOUT = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_page_cmd_ready,
  input  logic        i_page_cmd_valid,
  input  logic [15:0] i_page_cmd,
  input  logic        i_page_cmd_last,
  input  logic [15:0] i_page_cmd_id,
  input  logic [47:0] i_page_addr,
  input  logic [31:0] i_page_cmd_param,
  output logic        o_op_valid,
  output logic [1:0]  o_op_type,
  output logic [7:0]  o_op_data,
  input  logic        i_op_ready,
  input  logic        i_rb_n,
  output logic        o_cmp_valid,
  output logic [15:0] o_cmp_id,
  output logic [1:0]  o_cmp_status,
  input  logic        i_cmp_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD1,
    S_ADDR,
    S_CMD2,
    S_DELAY,
    S_RBWAIT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  state_t      post_addr, post_cmd2;
  logic        rdy_q, rdy_d;
  logic [15:0] cmd_q, cmd_d;
  logic        last_q, last_d;
  logic [15:0] id_q, id_d;
  logic [47:0] addr_q, addr_d;
  logic [2:0]  nadr_q, nadr_d;
  logic [11:0] dly_q, dly_d;
  logic        poll_q, poll_d;
  logic [2:0]  idx_q, idx_d;
  logic [11:0] cnt_q, cnt_d;
  logic [23:0] tmr_q, tmr_d;
  logic        sticky_q, sticky_d;
  logic        rb_s1_q, rb_s1_d;
  logic        rb_s2_q, rb_s2_d;
  logic        accept;
  logic        unused_param;

  assign unused_param = ^i_page_cmd_param[31:16];

  assign accept = (state_q == S_IDLE) && rdy_q && i_page_cmd_valid;

  // Where to go once the address phase (or the confirm) is finished.
  always_comb begin
    post_cmd2 = poll_q ? S_RBWAIT : S_DONE;
    post_addr = (cmd_q[15:8] != 8'h00) ? S_CMD2 : post_cmd2;
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    last_d   = last_q;
    id_d     = id_q;
    addr_d   = addr_q;
    nadr_d   = nadr_q;
    dly_d    = dly_q;
    poll_d   = poll_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    tmr_d    = '0;
    sticky_d = sticky_q;
    rb_s1_d  = i_rb_n;
    rb_s2_d  = rb_s1_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          cmd_d   = i_page_cmd;
          last_d  = i_page_cmd_last;
          id_d    = i_page_cmd_id;
          addr_d  = i_page_addr;
          nadr_d  = (i_page_cmd_param[3:1] > 3'd6) ? 3'd6
                                                    : i_page_cmd_param[3:1];
          dly_d   = i_page_cmd_param[15:4];
          poll_d  = i_page_cmd_param[0];
          idx_d   = '0;
          state_d = S_CMD1;
        end
      end
      S_CMD1: begin
        if (i_op_ready) begin
          idx_d   = '0;
          state_d = (nadr_q == 3'd0) ? post_addr : S_ADDR;
        end
      end
      S_ADDR: begin
        // Address register shifts so the current byte is always [7:0].
        if (i_op_ready) begin
          addr_d = {8'h00, addr_q[47:8]};
          idx_d  = idx_q + 3'd1;
          if (idx_d == nadr_q) begin
            state_d = post_addr;
          end
        end
      end
      S_CMD2: begin
        if (i_op_ready) begin
          cnt_d   = dly_q;
          state_d = (dly_q == 12'd0) ? post_cmd2 : S_DELAY;
        end
      end
      S_DELAY: begin
        cnt_d = cnt_q - 12'd1;
        if (cnt_q <= 12'd1) begin
          cnt_d   = '0;
          state_d = post_cmd2;
        end
      end
      S_RBWAIT: begin
        if (rb_s2_q) begin
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q + 24'd1;
          if (tmr_d == RB_TIMEOUT) begin
            sticky_d = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!last_q) begin
          state_d = S_IDLE;
        end else if (i_cmp_ready) begin
          sticky_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    rdy_d = (state_q == S_IDLE) && !accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rdy_q    <= 1'b0;
      cmd_q    <= '0;
      last_q   <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      nadr_q   <= '0;
      dly_q    <= '0;
      poll_q   <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
      sticky_q <= 1'b0;
      rb_s1_q  <= 1'b0;
      rb_s2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      cmd_q    <= cmd_d;
      last_q   <= last_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      nadr_q   <= nadr_d;
      dly_q    <= dly_d;
      poll_q   <= poll_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      sticky_q <= sticky_d;
      rb_s1_q  <= rb_s1_d;
      rb_s2_q  <= rb_s2_d;
    end
  end

  always_comb begin
    o_op_valid = 1'b0;
    o_op_type  = 2'd0;
    o_op_data  = 8'h00;
    case (state_q)
      S_CMD1: begin
        o_op_valid = 1'b1;
        o_op_data  = cmd_q[7:0];
      end
      S_ADDR: begin
        o_op_valid = 1'b1;
        o_op_type  = 2'd1;
        o_op_data  = addr_q[7:0];
      end
      S_CMD2: begin
        o_op_valid = 1'b1;
        o_op_data  = cmd_q[15:8];
      end
      default: ;
    endcase
  end

  assign o_page_cmd_ready = rdy_q;
  assign o_cmp_valid      = (state_q == S_DONE) && last_q;
  assign o_cmp_id         = o_cmp_valid ? id_q : 16'h0000;
  assign o_cmp_status     = o_cmp_valid ? {1'b0, sticky_q} : 2'b00;

endmodule

// File: tb/tb_page_cmd_exec.sv
// Directed bench for page_cmd_exec: op stream, delay/poll latency,
// sticky timeout status, handshake stability and mid-sequence reset.
module tb_page_cmd_exec;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        o_page_cmd_ready;
  logic        i_page_cmd_valid;
  logic [15:0] i_page_cmd;
  logic        i_page_cmd_last;
  logic [15:0] i_page_cmd_id;
  logic [47:0] i_page_addr;
  logic [31:0] i_page_cmd_param;
  logic        o_op_valid;
  logic [1:0]  o_op_type;
  logic [7:0]  o_op_data;
  logic        i_op_ready;
  logic        i_rb_n;
  logic        o_cmp_valid;
  logic [15:0] o_cmp_id;
  logic [1:0]  o_cmp_status;
  logic        i_cmp_ready;

  page_cmd_exec #(.RB_TIMEOUT(24'd16)) dut (
    .clk              (clk),
    .rst              (rst),
    .o_page_cmd_ready (o_page_cmd_ready),
    .i_page_cmd_valid (i_page_cmd_valid),
    .i_page_cmd       (i_page_cmd),
    .i_page_cmd_last  (i_page_cmd_last),
    .i_page_cmd_id    (i_page_cmd_id),
    .i_page_addr      (i_page_addr),
    .i_page_cmd_param (i_page_cmd_param),
    .o_op_valid       (o_op_valid),
    .o_op_type        (o_op_type),
    .o_op_data        (o_op_data),
    .i_op_ready       (i_op_ready),
    .i_rb_n           (i_rb_n),
    .o_cmp_valid      (o_cmp_valid),
    .o_cmp_id         (o_cmp_id),
    .o_cmp_status     (o_cmp_status),
    .i_cmp_ready      (i_cmp_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_op_cyc = 0;
  bit chk_en = 1'b0;
  bit op_rand = 1'b0;
  bit st_acc = 1'b0;
  bit prev_stall = 1'b0;
  logic [9:0]  prev_op = '0;
  logic [9:0]  exp_ops[$];
  logic [17:0] exp_cmp[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: condition not met (cyc %0d)", nm, cyc);
  endtask

  // Reference: ops a page command must produce.
  task automatic model_ops(input logic [15:0] cmd, input logic [47:0] addr,
                           input logic [31:0] prm);
    int n;
    n = int'(prm[3:1]);
    if (n > 6) n = 6;
    exp_ops.push_back({2'd0, cmd[7:0]});
    for (int k = 0; k < n; k++) exp_ops.push_back({2'd1, addr[8*k +: 8]});
    if (cmd[15:8] != 8'h00) exp_ops.push_back({2'd0, cmd[15:8]});
  endtask

  // Reference: clocks from last op transfer to the DONE state.
  function automatic int model_lat(input logic [15:0] cmd,
                                   input logic [31:0] prm, input bit rb_hi);
    int l;
    l = 1;
    if (cmd[15:8] != 8'h00) l += int'(prm[15:4]);
    if (prm[0]) l += rb_hi ? 1 : TO;
    return l;
  endfunction

  always @(negedge clk) begin
    if (!chk_en) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall)
        chk("op_stable", {o_op_valid, o_op_type, o_op_data}, {1'b1, prev_op});
      if (o_op_valid && i_op_ready) begin
        if (exp_ops.size() == 0) fail("op_extra");
        else chk("op", {o_op_type, o_op_data}, exp_ops.pop_front());
        last_op_cyc <= cyc;
      end
      prev_stall <= o_op_valid && !i_op_ready;
      prev_op    <= {o_op_type, o_op_data};
      if (o_cmp_valid && exp_cmp.size() == 0) fail("cmp_extra");
      else if (o_cmp_valid && i_cmp_ready)
        chk("cmp", {o_cmp_id, o_cmp_status}, exp_cmp.pop_front());
    end
  end

  initial begin
    i_op_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i_op_ready = op_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rdy"}, o_page_cmd_ready, 0);
    chk({tag, "_opv"}, {o_op_valid, o_op_type, o_op_data}, 0);
    chk({tag, "_cmp"}, {o_cmp_valid, o_cmp_id, o_cmp_status}, 0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_rdy_lo", o_page_cmd_ready, 0);
    @(negedge clk);
    chk("rel_rdy_hi", o_page_cmd_ready, 1);
    chk_en = 1'b1;
  endtask

  task automatic send(input logic [15:0] cmd, input logic [47:0] addr,
                      input logic [31:0] prm, input bit last,
                      input logic [15:0] id, input bit rb_hi,
                      input int cmp_wait, input bit spur);
    int n, lat, h;
    i_rb_n = rb_hi;
    repeat (3) @(posedge clk);
    #1;
    n = 0;
    while (!o_page_cmd_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!o_page_cmd_ready) fail("wait_ready");
    model_ops(cmd, addr, prm);
    lat = model_lat(cmd, prm, rb_hi);
    if (prm[0] && !rb_hi) st_acc = 1'b1;
    if (last) exp_cmp.push_back({id, 1'b0, st_acc});
    i_page_cmd       = cmd;
    i_page_addr      = addr;
    i_page_cmd_param = prm;
    i_page_cmd_last  = last;
    i_page_cmd_id    = id;
    i_page_cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    i_page_cmd_valid = 1'b0;
    chk("ready_drop", o_page_cmd_ready, 0);
    n = 0;
    while (exp_ops.size() != 0 && n < 4000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_ops.size() != 0) begin
      fail("ops_drain");
      exp_ops.delete();
    end
    if (spur) begin
      i_page_cmd       = 16'h00EE;
      i_page_cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      i_page_cmd_valid = 1'b0;
    end
    n = 0;
    if (last) begin
      while (!o_cmp_valid && n < 4000) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (!o_cmp_valid) begin
        fail("cmp_wait");
        exp_cmp.delete();
      end else begin
        chk("cmp_lat", cyc - last_op_cyc, lat);
        repeat (cmp_wait) begin
          @(negedge clk);
          #1;
          chk("cmp_hold", {o_cmp_valid, o_cmp_id}, {1'b1, id});
        end
        @(posedge clk);
        #1;
        i_cmp_ready = 1'b1;
        @(negedge clk);
        #1;
        h = cyc;
        @(posedge clk);
        #1;
        i_cmp_ready = 1'b0;
        n = 0;
        while (!o_page_cmd_ready && n < 50) begin
          @(negedge clk);
          #1;
          n++;
        end
        chk("ready_ret_c", cyc - h, 2);
      end
      st_acc = 1'b0;
    end else begin
      while (!o_page_cmd_ready && n < 4000) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("ready_ret", cyc - last_op_cyc, lat + 2);
    end
  endtask

  initial begin
    rst              = 1'b1;
    i_page_cmd_valid = 1'b0;
    i_page_cmd       = '0;
    i_page_cmd_last  = 1'b0;
    i_page_cmd_id    = '0;
    i_page_addr      = '0;
    i_page_cmd_param = '0;
    i_rb_n           = 1'b1;
    i_cmp_ready      = 1'b0;
    #2;
    check_idle_outputs("rst");

    // Pin the reference model with hand-derived values.
    model_ops(16'hD160, 48'h000000000800, {16'h0, 12'd5, 3'h4, 1'b1});
    chk("model_n", exp_ops.size(), 6);
    chk("model_op0", exp_ops[0], 10'h060);
    chk("model_op2", exp_ops[2], 10'h108);
    chk("model_op5", exp_ops[5], 10'h0D1);
    exp_ops.delete();
    model_ops(16'h3000, 48'hAABBCCDDEEFF, {16'h0, 12'd0, 3'h7, 1'b0});
    chk("model_clamp_n", exp_ops.size(), 8);
    chk("model_clamp_6", exp_ops[6], 10'h1AA);
    exp_ops.delete();
    chk("model_lat_pair",
        model_lat(16'hD060, {16'h0, 12'h800, 3'h4, 1'b1}, 1'b1), 2050);
    chk("model_lat_to",
        model_lat(16'h1080, {16'h0, 12'd3, 3'h2, 1'b1}, 1'b0), 20);

    release_reset();

    // Multi-plane erase pair, second half with stalling PHY.
    send(16'hD160, 48'h000000000800, {16'h0, 12'd5, 3'h4, 1'b1},
         1'b0, 16'h0005, 1'b1, 0, 1'b0);
    op_rand = 1'b1;
    send(16'hD060, 48'h000000000800, {16'h0, 12'h800, 3'h4, 1'b1},
         1'b1, 16'h0005, 1'b1, 2, 1'b1);
    op_rand = 1'b0;

    // No confirm, no address, no poll.
    send(16'h0070, 48'h0, 32'h0, 1'b1, 16'h0007, 1'b1, 0, 1'b0);

    // R/B# stuck low: timeout status.
    send(16'h1080, 48'h000000001234, {16'h0, 12'd3, 3'h2, 1'b1},
         1'b1, 16'h0009, 1'b0, 1, 1'b0);

    // Sticky status across pages, cleared for the next request.
    send(16'hD160, 48'h000000001000, {16'h0, 12'd2, 3'h3, 1'b1},
         1'b0, 16'h000A, 1'b0, 0, 1'b0);
    send(16'hD060, 48'h000000001000, {16'h0, 12'd4, 3'h3, 1'b1},
         1'b1, 16'h000A, 1'b1, 0, 1'b0);
    send(16'h0070, 48'h0, {16'h0, 12'd0, 3'h0, 1'b1},
         1'b1, 16'h000B, 1'b1, 0, 1'b0);

    // Address-cycle clamp with stalling PHY.
    op_rand = 1'b1;
    send(16'h3000, 48'hAABBCCDDEEFF, {16'h0, 12'd0, 3'h7, 1'b0},
         1'b1, 16'h000C, 1'b1, 0, 1'b0);
    op_rand = 1'b0;

    // Reset while the third address byte is on the bus.
    begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      model_ops(16'h3000, 48'h000000554433_2211 & 48'hFFFFFFFFFFFF,
                {16'h0, 12'd0, 3'h5, 1'b0});
      i_page_cmd       = 16'h3000;
      i_page_addr      = 48'h0000_0055_4433_2211;
      i_page_cmd_param = {16'h0, 12'd0, 3'h5, 1'b0};
      i_page_cmd_last  = 1'b1;
      i_page_cmd_id    = 16'h00AB;
      i_page_cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      i_page_cmd_valid = 1'b0;
      n = 0;
      while (!(o_op_valid && o_op_type == 2'd1 && o_op_data == 8'h33)
             && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) fail("reach_addr2");
      #1;
      rst    = 1'b1;
      chk_en = 1'b0;
      #1;
      check_idle_outputs("midrst");
      exp_ops.delete();
      exp_cmp.delete();
      st_acc = 1'b0;
      release_reset();
    end
    send(16'h0070, 48'h0, 32'h0, 1'b1, 16'h00C3, 1'b1, 0, 1'b0);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1);
  end

endmodule
